// File: rtl/led_blink_driver_pkg.sv
// Shared board definitions for the LED blink driver and related status-LED blocks.
package led_blink_driver_pkg;

  // Board clock and the default 100 ms blink phase derived from it.
  localparam int unsigned BOARD_CLK_HZ       = 62_500_000;
  localparam int unsigned DEFAULT_ON_CYCLES  = BOARD_CLK_HZ / 10;
  localparam int unsigned DEFAULT_OFF_CYCLES = BOARD_CLK_HZ / 10;

  // Width of the blink-count fields (request, remaining, pending).
  localparam int unsigned BLINK_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } blink_state_e;

  // A request for zero blinks still produces one visible blink.
  function automatic logic [BLINK_W-1:0] norm_blinks(input logic [BLINK_W-1:0] n);
    return (n == '0) ? BLINK_W'(1) : n;
  endfunction

endpackage

// File: rtl/led_blink_if.sv
// Request/status bundle between control logic (master) and the blink driver (slave).
interface led_blink_if;
  import led_blink_driver_pkg::*;

  logic               event_i;
  logic [BLINK_W-1:0] blinks_i;
  logic               led_o;
  logic               busy_o;
  logic               done_o;
  logic               dropped_o;

  modport master (
    output event_i, blinks_i,
    input  led_o, busy_o, done_o, dropped_o
  );

  modport slave (
    input  event_i, blinks_i,
    output led_o, busy_o, done_o, dropped_o
  );

endinterface

// File: rtl/led_phase_timer.sv
// Loadable down-counter that parks at zero; zero_c flags the final cycle of a phase.
module led_phase_timer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             sysclk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic             zero_c
);

  logic [CNT_W-1:0] count_q;

  // Load has priority; otherwise count down and hold at zero.
  always_ff @(posedge sysclk) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (count_q != '0) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign zero_c = (count_q == '0);

endmodule

// File: rtl/led_blink_driver.sv
// Turns one-cycle blink requests into N on/off LED blinks with a one-deep request buffer.
module led_blink_driver
  import led_blink_driver_pkg::*;
#(
  parameter int unsigned ON_CYCLES  = DEFAULT_ON_CYCLES,
  parameter int unsigned OFF_CYCLES = DEFAULT_OFF_CYCLES,
  parameter int unsigned CNT_W      =
    $clog2(((ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES) + 1)
) (
  input  logic         sysclk,
  input  logic         reset_n,
  led_blink_if.slave   bus
);

  localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_CYCLES - 1);

  blink_state_e       state_q, state_d;
  logic [BLINK_W-1:0] rem_q, rem_d;
  logic [BLINK_W-1:0] pend_cnt_q, pend_cnt_d;
  logic               pend_valid_q, pend_valid_d;
  logic [BLINK_W-1:0] norm_c;
  logic               load_c;
  logic [CNT_W-1:0]   load_value_c;
  logic               zero_c;
  logic               complete_c;
  logic               drop_c;
  logic               led_d;
  logic               busy_d;

  led_phase_timer #(
    .CNT_W (CNT_W)
  ) u_phase_timer (
    .sysclk     (sysclk),
    .reset_n    (reset_n),
    .load       (load_c),
    .load_value (load_value_c),
    .zero_c     (zero_c)
  );

  // State, counters, pending buffer and registered outputs; reset clears everything.
  always_ff @(posedge sysclk) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      rem_q         <= '0;
      pend_cnt_q    <= '0;
      pend_valid_q  <= 1'b0;
      bus.led_o     <= 1'b0;
      bus.busy_o    <= 1'b0;
      bus.done_o    <= 1'b0;
      bus.dropped_o <= 1'b0;
    end else begin
      state_q       <= state_d;
      rem_q         <= rem_d;
      pend_cnt_q    <= pend_cnt_d;
      pend_valid_q  <= pend_valid_d;
      bus.led_o     <= led_d;
      bus.busy_o    <= busy_d;
      bus.done_o    <= complete_c;
      bus.dropped_o <= drop_c;
    end
  end

  // Next-state: phase sequencing, sequence completion and request buffering.
  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    pend_cnt_d   = pend_cnt_q;
    pend_valid_d = pend_valid_q;
    load_c       = 1'b0;
    load_value_c = ON_LOAD;
    complete_c   = 1'b0;
    drop_c       = 1'b0;
    norm_c       = norm_blinks(bus.blinks_i);

    case (state_q)
      ST_IDLE: begin
        if (bus.event_i) begin
          state_d = ST_ON;
          load_c  = 1'b1;
          rem_d   = norm_c;
        end
      end
      ST_ON: begin
        if (zero_c) begin
          state_d      = ST_OFF;
          load_c       = 1'b1;
          load_value_c = OFF_LOAD;
          rem_d        = rem_q - BLINK_W'(1);
        end
      end
      ST_OFF: begin
        if (zero_c) begin
          if (rem_q != '0) begin
            state_d = ST_ON;
            load_c  = 1'b1;
          end else begin
            complete_c = 1'b1;
            if (pend_valid_q) begin
              state_d      = ST_ON;
              load_c       = 1'b1;
              rem_d        = pend_cnt_q;
              pend_valid_d = 1'b0;
            end else if (bus.event_i) begin
              // A request on the last OFF cycle passes through the empty buffer.
              state_d = ST_ON;
              load_c  = 1'b1;
              rem_d   = norm_c;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if ((state_q != ST_IDLE) && bus.event_i) begin
      if (pend_valid_q) begin
        drop_c = 1'b1;
      end else if (!complete_c) begin
        pend_valid_d = 1'b1;
        pend_cnt_d   = norm_c;
      end
    end
  end

  // Output decode from the next state so the LED and busy flags are registered.
  always_comb begin
    led_d  = (state_d == ST_ON);
    busy_d = (state_d != ST_IDLE);
  end

endmodule

// File: tb/tb_led_blink_driver.sv
// Directed bench for led_blink_driver with ON_CYCLES=3, OFF_CYCLES=2.
module tb_led_blink_driver;

  logic sysclk;
  logic reset_n;
  int   checks;
  int   errors;

  led_blink_if bus ();

  led_blink_driver #(
    .ON_CYCLES  (3),
    .OFF_CYCLES (2)
  ) dut (
    .sysclk  (sysclk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag, input int cyc, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d observed=%0b expected=%0b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input int cyc,
                      input logic led, input logic busy, input logic done, input logic drop);
    chk({tag, ".led"},     cyc, bus.led_o,     led);
    chk({tag, ".busy"},    cyc, bus.busy_o,    busy);
    chk({tag, ".done"},    cyc, bus.done_o,    done);
    chk({tag, ".dropped"}, cyc, bus.dropped_o, drop);
  endtask

  // Cycle c drives the inputs sampled at edge c; bit k of each pattern is the
  // expected output in the cycle after edge k-1 (i.e. bit 1 = first cycle after t).
  task automatic run(input string tag, input int ncyc,
                     input logic [31:0] ev, input logic [127:0] bl, input logic [31:0] rst,
                     input logic [31:0] led_p, input logic [31:0] busy_p,
                     input logic [31:0] done_p, input logic [31:0] drop_p);
    for (int c = 0; c < ncyc; c++) begin
      bus.event_i  = ev[c];
      bus.blinks_i = bl[c*4 +: 4];
      reset_n      = ~rst[c];
      @(negedge sysclk);
      bus.event_i = 1'b0;
      reset_n     = 1'b1;
      chk4(tag, c + 1, led_p[c+1], busy_p[c+1], done_p[c+1], drop_p[c+1]);
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    reset_n      = 1'b0;
    bus.event_i  = 1'b0;
    bus.blinks_i = 4'd0;

    repeat (4) @(negedge sysclk);
    chk4("reset_held", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      @(negedge sysclk);
      chk4("idle", i, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Two blinks: on 1-3 and 6-8, done at 11.
    run("two_blinks", 12, 32'h1, 128'h2, 32'h0,
        32'h0000_01CE, 32'h0000_07FE, 32'h0000_0800, 32'h0);

    // Zero count behaves as one blink, done at 6.
    run("zero_count", 7, 32'h1, 128'h0, 32'h0,
        32'h0000_000E, 32'h0000_003E, 32'h0000_0040, 32'h0);

    // Buffered 3 at t+2, 5 at t+3 dropped; pending starts with done at 6, final done 21.
    run("buffer_drop", 22, 32'hD, 128'h5301, 32'h0,
        32'h0007_39CE, 32'h001F_FFFE, 32'h0020_0040, 32'h0000_0010);

    // Reset during the first OFF phase with a pending request: all quiet afterwards.
    run("mid_reset", 20, 32'h5, 128'h104, 32'h10,
        32'h0000_000E, 32'h0000_001E, 32'h0, 32'h0);

    // Request on the last OFF cycle rides through; no drop.
    run("last_off_req", 12, 32'h21, 128'h10_0001, 32'h0,
        32'h0000_01CE, 32'h0000_07FE, 32'h0000_0840, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_blink_driver.md
Name: led_blink_driver

Overview:
- Output-side companion to the board's button debouncer. The debouncer turns a noisy pin into clean one-cycle events; this block turns one-cycle internal events into human-visible LED blink sequences.
- Each request asks for N blinks. One further request can be buffered while a sequence runs; any request beyond that is dropped and flagged.
- Sits between control logic (for example, debounced button events) and an LED pin.

Parameters:
- ON_CYCLES, default 6250000: LED-on duration of each blink, in sysclk cycles; must be >= 1.
- OFF_CYCLES, default 6250000: LED-off gap after each blink, including the last; must be >= 1.
- CNT_W, default $clog2(max(ON_CYCLES,OFF_CYCLES)+1): width of the phase counter.

Ports:
- sysclk  input  1  system clock
- reset_n  input  1  reset; synchronous, active-low
- event_i  input  1  blink request; every cycle it is high counts as one request
- blinks_i  input  4  blink count, sampled with event_i; 0 is treated as 1
- led_o  output  1  LED drive, registered
- busy_o  output  1  a sequence is running
- done_o  output  1  one-cycle pulse when a sequence completes
- dropped_o  output  1  one-cycle pulse when a request is discarded

Behaviour:
- Reset (reset_n low at a sysclk edge):
  - led_o, busy_o, done_o, dropped_o all 0.
  - State IDLE; pending buffer empty; counters 0.
  - Reset wins over every other event, including mid-sequence: led_o is 0 in the cycle after the reset edge and the pending request is discarded.
- States: IDLE, ON, OFF.
- IDLE:
  - On event_i=1, latch n = (blinks_i==0 ? 1 : blinks_i) into the remaining counter and load the phase counter with ON_CYCLES-1.
  - Go to ON. led_o=1 and busy_o=1 from the next cycle.
  - Latency, event sampled to LED on: 1 cycle.
- ON:
  - led_o=1; the phase counter decrements each cycle.
  - When it reaches 0: load OFF_CYCLES-1, go to OFF, decrement remaining.
- OFF:
  - led_o=0, busy_o=1.
  - When the phase counter reaches 0 and remaining != 0: load ON_CYCLES-1 and go to ON.
  - When the phase counter reaches 0 and remaining == 0: the sequence is complete.
- Completion:
  - In the cycle after the last OFF cycle, done_o=1 for exactly one cycle.
  - If pending is valid: the pending request starts in that same cycle (state ON, led_o=1, busy_o=1) and pending is cleared.
  - Otherwise: state IDLE, busy_o=0.
- Sequence length: exactly n*(ON_CYCLES+OFF_CYCLES) busy cycles.
- Requests while busy (any cycle where state != IDLE):
  - Pending empty: store the normalised count in pending.
  - Pending full: pending is unchanged (first request is kept); dropped_o=1 in the next cycle.
- Request on the last OFF cycle:
  - Pending empty: the request is stored in pending, so it starts together with the done_o pulse.
  - Pending full: the request is dropped.
- Widths: the remaining and pending counters are 4 bits. Counters never wrap: every reload happens exactly when the counter reaches 0.
- done_o and dropped_o may be high in the same cycle.

Decomposition:
- Shared board package holds:
  - the state enum (IDLE/ON/OFF);
  - default ON_CYCLES/OFF_CYCLES constants derived from the board clock frequency (100 ms at the board clock).
- One sub-module: led_phase_timer, a loadable CNT_W-bit down-counter.
  - Inputs: load, load_value.
  - Output: zero flag.
  - Reused by later status-LED blocks.

Test Plan (ON_CYCLES=3, OFF_CYCLES=2):
- Reset held 4 cycles, then released -> led_o, busy_o, done_o, dropped_o all 0; with no event, led_o stays 0 for 50 cycles.
- event_i=1, blinks_i=2 sampled at edge t:
  - led_o=1 in t+1..t+3 and t+6..t+8;
  - led_o=0 in t+4..t+5 and t+9..t+10;
  - busy_o=1 in t+1..t+10;
  - done_o=1 only in t+11, with busy_o=0 in t+11.
- event_i with blinks_i=0 -> exactly one blink: led_o high 3 cycles, done_o at t+6.
- blinks_i=1 at t, blinks_i=3 at t+2, blinks_i=5 at t+3:
  - dropped_o=1 at t+4;
  - t+6 has done_o=1 and led_o=1, then 3 blinks follow;
  - final done_o at t+21.
- blinks_i=4 at t, reset_n=0 at edge t+4 (mid second phase) with a pending request present -> led_o=0 and busy_o=0 from t+5; after release, no blink occurs (pending was cleared).
- blinks_i=1 at t, second event at t+5 (last OFF cycle) -> done_o=1 and led_o=1 at t+6; second sequence ends with done_o at t+11; dropped_o never asserted.
